// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a byte-serial divider.
// Optional WAIT-state abort is enabled by defining DIV_TIMEOUT_EN.
module div_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_z,
    input  logic [31:0] req0_d,
    input  logic        req0_select,
    input  logic        req0_sign,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_z,
    input  logic [31:0] req1_d,
    input  logic        req1_select,
    input  logic        req1_sign,

    output logic        resp_valid,
    output logic        resp_id,
    output logic [63:0] resp_qr,
    output logic        resp_sign,
    output logic        resp_err,
    output logic        busy,

    output logic        div_push,
    output logic [7:0]  div_data_in,
    output logic        div_sign,
    output logic        div_select,
    input  logic        div_pull,
    input  logic [7:0]  div_data_out,
    input  logic        div_sign_out
);

    typedef enum logic [2:0] {StIdle, StSend, StWait, StRecv, StResp} state_t;

    state_t      state;
    logic [2:0]  byte_cnt;
    logic [63:0] shreg;
    logic        cur_id;
    logic        last_id;
    logic        sign_out_q;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

`ifdef DIV_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

    logic [WaitW-1:0] wait_cnt;
    logic             resp_err_q;

    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    // Tie goes to whoever was not granted last; a lone valid always wins.
    logic        grant_id;
    logic [31:0] sel_z;
    logic [31:0] sel_d;
    logic        sel_select;
    logic        sel_sign;

    always_comb begin
        grant_id   = (req0_valid && req1_valid) ? ~last_id : req1_valid;
        sel_z      = grant_id ? req1_z : req0_z;
        sel_d      = grant_id ? req1_d : req0_d;
        sel_select = grant_id ? req1_select : req0_select;
        sel_sign   = grant_id ? req1_sign : req0_sign;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StIdle;
            byte_cnt    <= 3'd0;
            shreg       <= 64'd0;
            cur_id      <= 1'b0;
            last_id     <= 1'b1;
            sign_out_q  <= 1'b0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_qr     <= 64'd0;
            resp_sign   <= 1'b0;
            busy        <= 1'b0;
            div_push    <= 1'b0;
            div_data_in <= 8'd0;
            div_sign    <= 1'b0;
            div_select  <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            wait_cnt    <= '0;
            resp_err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (req0_ready && (req0_valid || req1_valid)) begin
                        state       <= StSend;
                        req0_ready  <= 1'b0;
                        req1_ready  <= 1'b0;
                        busy        <= 1'b1;
                        cur_id      <= grant_id;
                        last_id     <= grant_id;
                        div_push    <= 1'b1;
                        div_data_in <= sel_z[31:24];
                        shreg       <= {sel_z[23:0], sel_d, 8'h00};
                        div_sign    <= sel_sign;
                        div_select  <= sel_select;
                    end else begin
                        req0_ready <= 1'b1;
                        req1_ready <= 1'b1;
                    end
                end
                StSend: begin
                    byte_cnt <= byte_cnt + 3'd1;
                    if (byte_cnt == 3'd7) begin
                        state       <= StWait;
                        div_push    <= 1'b0;
                        div_data_in <= 8'd0;
`ifdef DIV_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end else begin
                        div_data_in <= shreg[63:56];
                        shreg       <= shreg << 8;
                    end
                end
                StWait: begin
                    // A pull on the limit cycle still wins over the abort.
                    if (div_pull) begin
                        state      <= StRecv;
                        sign_out_q <= div_sign_out;
                    end
`ifdef DIV_TIMEOUT_EN
                    else if (wait_cnt == WaitLast) begin
                        state      <= StResp;
                        resp_valid <= 1'b1;
                        resp_id    <= cur_id;
                        resp_qr    <= 64'd0;
                        resp_sign  <= 1'b0;
                        resp_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                StRecv: begin
                    byte_cnt <= byte_cnt + 3'd1;
                    shreg    <= {div_data_out, shreg[63:8]};
                    if (byte_cnt == 3'd7) begin
                        state      <= StResp;
                        resp_valid <= 1'b1;
                        resp_id    <= cur_id;
                        resp_qr    <= {div_data_out, shreg[63:8]};
                        resp_sign  <= sign_out_q;
`ifdef DIV_TIMEOUT_EN
                        resp_err_q <= 1'b0;
`endif
                    end
                end
                StResp: begin
                    state      <= StIdle;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    req0_ready <= 1'b1;
                    req1_ready <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
